// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - register map, CR/SR bit indices and bus FSM states for apb_timer
package apb_timer_pkg;

  localparam logic [2:0] REG_CR  = 3'd0;
  localparam logic [2:0] REG_PSC = 3'd1;
  localparam logic [2:0] REG_ARR = 3'd2;
  localparam logic [2:0] REG_CNT = 3'd3;
  localparam logic [2:0] REG_SR  = 3'd4;

  localparam int CR_EN  = 0;
  localparam int CR_CLR = 1;
  localparam int CR_IE  = 2;
  localparam int SR_UIF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_t;

endpackage

// File: rtl/apb_timer_core.sv
// rtl/apb_timer_core.sv - prescaler, auto-reload up-counter, update flag and registered interrupt
module apb_timer_core #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ie,
  input  logic             uif_clr,
  input  logic [PSC_W-1:0] psc,
  input  logic [31:0]      arr,
  output logic [31:0]      cnt,
  output logic             uif,
  output logic             irq
);

  logic [PSC_W-1:0] psc_cnt;
  logic             tick;
  logic             wrap;

  // A clear on the same edge swallows the tick, so no stray update event either.
  assign tick = en && !clr && (psc_cnt == psc);
  assign wrap = tick && (cnt >= arr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt <= '0;
      cnt     <= '0;
      uif     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (clr) begin
        psc_cnt <= '0;
        cnt     <= '0;
      end else if (en) begin
        if (tick) begin
          psc_cnt <= '0;
          cnt     <= wrap ? 32'd0 : cnt + 32'd1;
        end else begin
          psc_cnt <= psc_cnt + PSC_W'(1);
        end
      end

      // Hardware set beats a software clear on the same edge.
      if (wrap) begin
        uif <= 1'b1;
      end else if (uif_clr) begin
        uif <= 1'b0;
      end

      irq <= uif && ie;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB completer wrapping the timer core: bus FSM, register file and read mux
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int          PSC_W   = 16,
  parameter logic [31:0] ARR_RST = 32'hFFFF_FFFF
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tim_irq
);

  bus_state_t       state;
  logic [2:0]       reg_sel;
  logic             wr_commit;
  logic             cr_en;
  logic             cr_ie;
  logic [PSC_W-1:0] psc;
  logic [31:0]      arr;
  logic [31:0]      cnt;
  logic             uif;
  logic             clr;
  logic             uif_clr;
  logic [31:0]      rdata;
  logic             unused_paddr;

  assign reg_sel      = PADDR[4:2];
  assign unused_paddr = ^{PADDR[31:5], PADDR[1:0]};

  // Writes land on the WAIT->RESP edge, and only if the master still holds the access phase.
  assign wr_commit = (state == WAIT) && PSEL && PENABLE && PWRITE;
  assign clr       = wr_commit && (reg_sel == REG_CR) && PWDATA[CR_CLR];
  assign uif_clr   = wr_commit && (reg_sel == REG_SR) && PWDATA[SR_UIF];

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CR: begin
        rdata[CR_EN] = cr_en;
        rdata[CR_IE] = cr_ie;
      end
      REG_PSC: rdata[PSC_W-1:0] = psc;
      REG_ARR: rdata = arr;
      REG_CNT: rdata = cnt;
      REG_SR:  rdata[SR_UIF] = uif;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state  <= IDLE;
      PREADY <= 1'b0;
      PRDATA <= '0;
      cr_en  <= 1'b0;
      cr_ie  <= 1'b0;
      psc    <= '0;
      arr    <= ARR_RST;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && PENABLE) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          state  <= RESP;
          PREADY <= 1'b1;
          PRDATA <= rdata;
          if (wr_commit) begin
            case (reg_sel)
              REG_CR: begin
                cr_en <= PWDATA[CR_EN];
                cr_ie <= PWDATA[CR_IE];
              end
              REG_PSC: psc <= PWDATA[PSC_W-1:0];
              REG_ARR: arr <= PWDATA;
              default: ;
            endcase
          end
        end
        RESP: begin
          state  <= IDLE;
          PREADY <= 1'b0;
          PRDATA <= '0;
        end
        default: begin
          state  <= IDLE;
          PREADY <= 1'b0;
          PRDATA <= '0;
        end
      endcase
    end
  end

  apb_timer_core #(
    .PSC_W(PSC_W)
  ) u_core (
    .clk     (PCLK),
    .rst     (PRESET),
    .en      (cr_en),
    .clr     (clr),
    .ie      (cr_ie),
    .uif_clr (uif_clr),
    .psc     (psc),
    .arr     (arr),
    .cnt     (cnt),
    .uif     (uif),
    .irq     (tim_irq)
  );

endmodule

// File: tb/tb_apb_timer.sv
// tb/tb_apb_timer.sv - self-checking bench for apb_timer: register table, timing sequences, scoreboard
module tb_apb_timer;
  import apb_timer_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        tim_irq;

  always #5 PCLK = ~PCLK;

  apb_timer #(
    .PSC_W   (16),
    .ARR_RST (32'hFFFF_FFFF)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .tim_irq (tim_irq)
  );

  localparam logic [31:0] A_CR  = 32'h00;
  localparam logic [31:0] A_PSC = 32'h04;
  localparam logic [31:0] A_ARR = 32'h08;
  localparam logic [31:0] A_CNT = 32'h0C;
  localparam logic [31:0] A_SR  = 32'h10;

  typedef struct {
    logic        chk;
    logic [31:0] addr;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_ready_cyc = 0;
  int   irq_rises = 0;
  int   irq_rise_cyc = 0;
  logic irq_prev = 1'b0;
  logic ready_prev = 1'b0;
  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t tbl[$];

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (PREADY === 1'b1) begin
      last_ready_cyc = cyc;
      check("pready_single", 32'(ready_prev), 32'd0);
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) check($sformatf("rd_%0h", mon_e.addr), PRDATA, mon_e.exp);
      end
    end else begin
      check("prdata_idle", PRDATA, 32'd0);
    end
    ready_prev = PREADY;
    if (tim_irq === 1'b1 && irq_prev === 1'b0) begin
      irq_rises++;
      irq_rise_cyc = cyc;
    end
    irq_prev = tim_irq;
  end

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp);
    sb_t e;
    int  n;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    e.chk = !wr; e.addr = addr; e.exp = exp;
    sb_q.push_back(e);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (PREADY !== 1'b1 && n < 8);
    if (PREADY !== 1'b1) check("pready_timeout", 32'(PREADY), 32'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
    apb(1'b1, addr, data, 32'd0);
  endtask

  task automatic rd_reg(input logic [31:0] addr, input logic [31:0] exp);
    apb(1'b0, addr, 32'd0, exp);
  endtask

  task automatic wait_cyc(input int target);
    if (cyc > target) check("bench_late", cyc, target);
    while (cyc < target) @(negedge PCLK);
  endtask

  task automatic wait_irq_rise(input int prev, input int limit);
    int n;
    n = 0;
    while (irq_rises == prev && n < limit) begin
      @(negedge PCLK);
      n++;
    end
    check("irq_rise_seen", irq_rises, prev + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int ec, c1, rise1, r;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PRESET = 1'b0;
    #1 PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    check("rst_pready", 32'(PREADY), 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_irq", 32'(tim_irq), 32'd0);

    // Reset values of every slot, masking, aliasing and ignored writes.
    for (int a = 0; a < 8; a++)
      tbl.push_back('{1'b0, 32'(a * 4), (a == 2) ? 32'hFFFF_FFFF : 32'd0});
    tbl.push_back('{1'b1, A_PSC, 32'hFFFF_FFFF});
    tbl.push_back('{1'b0, A_PSC, 32'h0000_FFFF});
    tbl.push_back('{1'b1, A_ARR, 32'h1234_5678});
    tbl.push_back('{1'b0, A_ARR, 32'h1234_5678});
    tbl.push_back('{1'b0, 32'h28, 32'h1234_5678});
    tbl.push_back('{1'b1, A_CNT, 32'hDEAD_BEEF});
    tbl.push_back('{1'b0, A_CNT, 32'd0});
    tbl.push_back('{1'b1, 32'h14, 32'hFFFF_FFFF});
    tbl.push_back('{1'b0, 32'h14, 32'd0});
    tbl.push_back('{1'b0, 32'h18, 32'd0});
    tbl.push_back('{1'b1, A_SR, 32'd0});
    tbl.push_back('{1'b0, A_SR, 32'd0});
    tbl.push_back('{1'b1, A_CR, 32'h6});
    tbl.push_back('{1'b0, A_CR, 32'h4});
    tbl.push_back('{1'b1, A_CR, 32'h0});
    tbl.push_back('{1'b0, A_CR, 32'h0});
    tbl.push_back('{1'b1, A_PSC, 32'h0});
    foreach (tbl[i]) begin
      if (tbl[i].wr) wr_reg(tbl[i].addr, tbl[i].data);
      else rd_reg(tbl[i].addr, tbl[i].data);
    end

    // PSC=3, ARR=4: one count per 4 cycles, wrap and UIF every 20.
    wr_reg(A_PSC, 32'd3);
    wr_reg(A_ARR, 32'd4);
    r = irq_rises;
    wr_reg(A_CR, 32'h5);
    ec = last_ready_cyc;
    for (int k = 1; k <= 4; k++) begin
      wait_cyc(ec + 4 * k);
      check($sformatf("cnt_step%0d", k), dut.cnt, 32'(k));
    end
    wait_cyc(ec + 19);
    check("cnt_before_wrap", dut.cnt, 32'd4);
    check("uif_before_wrap", 32'(dut.uif), 32'd0);
    wait_cyc(ec + 20);
    check("cnt_wrap", dut.cnt, 32'd0);
    check("uif_wrap", 32'(dut.uif), 32'd1);
    check("irq_lags_uif", 32'(tim_irq), 32'd0);
    wait_irq_rise(r, 10);
    check("irq_first_rise", irq_rise_cyc - ec, 32'd21);
    rise1 = irq_rise_cyc;

    wr_reg(A_SR, 32'd1);
    c1 = last_ready_cyc;
    wait_cyc(c1 + 1);
    check("irq_cleared", 32'(tim_irq), 32'd0);
    rd_reg(A_SR, 32'd0);
    r = irq_rises;
    wait_irq_rise(r, 30);
    check("irq_period", irq_rise_cyc - rise1, 32'd20);

    // W1C landing on the wrap edge: the set wins.
    wait_cyc(ec + 56);
    wr_reg(A_SR, 32'd1);
    check("w1c_on_wrap_edge", last_ready_cyc, ec + 60);
    rd_reg(A_SR, 32'd1);
    check("irq_held", 32'(tim_irq), 32'd1);

    // CLR while running at PSC=0.
    wr_reg(A_CR, 32'h2);
    wr_reg(A_SR, 32'd1);
    wr_reg(A_PSC, 32'd0);
    wr_reg(A_ARR, 32'd100);
    wr_reg(A_CR, 32'h1);
    repeat (5) @(negedge PCLK);
    check("running_before_clr", 32'(dut.cnt > 32'd3), 32'd1);
    wr_reg(A_CR, 32'h3);
    ec = last_ready_cyc;
    for (int k = 1; k <= 3; k++) begin
      wait_cyc(ec + k);
      check($sformatf("cnt_after_clr%0d", k), dut.cnt, 32'(k));
    end
    rd_reg(A_CR, 32'h1);

    // Lower ARR below a running CNT: wraps on the next tick.
    wait_cyc(ec + 12);
    wr_reg(A_ARR, 32'd2);
    check("arr_commit_edge", last_ready_cyc, ec + 16);
    wait_cyc(ec + 17);
    check("cnt_arr_lowered", dut.cnt, 32'd0);
    check("uif_arr_lowered", 32'(dut.uif), 32'd1);
    wait_cyc(ec + 18);
    check("cnt_after_lowered", dut.cnt, 32'd1);
    rd_reg(A_SR, 32'd1);

    // Reset in the WAIT state of a write to ARR.
    wr_reg(A_CR, 32'h5);
    c1 = last_ready_cyc;
    wait_cyc(c1 + 1);
    check("irq_before_reset", 32'(tim_irq), 32'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_ARR; PWDATA = 32'd5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    check("in_wait", {30'd0, dut.state}, {30'd0, WAIT});
    PRESET = 1'b1;
    #1;
    check("rst_mid_pready", 32'(PREADY), 32'd0);
    check("rst_mid_irq", 32'(tim_irq), 32'd0);
    check("rst_mid_arr", dut.arr, 32'hFFFF_FFFF);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    rd_reg(A_ARR, 32'hFFFF_FFFF);
    rd_reg(A_CR, 32'd0);
    rd_reg(A_CNT, 32'd0);
    rd_reg(A_SR, 32'd0);
    wr_reg(A_ARR, 32'd5);
    rd_reg(A_ARR, 32'd5);
    repeat (2) @(negedge PCLK);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
